cache_axi_bridge: RTL and testbench

//  Downstream neighbour of the 2-way cache: converts its rd_req/ret_* and wr_req channels into AXI3/4

---
 rtl/cache_axi_bridge_pkg.sv | 39 +++
 rtl/cache_axi_bridge_wr_channel.sv | 132 +++++++++++++
 rtl/cache_axi_bridge.sv | 158 +++++++++++++++
 tb/tb_cache_axi_bridge.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_axi_bridge_pkg.sv
// Shared encodings, FSM state types and AXI field helpers for the cache-to-AXI bridge.
package cache_axi_bridge_pkg;

  // Words per cache line unless the top is parameterised otherwise.
  localparam int DEFAULT_LINE_WORDS = 4;

  // Cache request type encodings (rd_type / wr_type).
  localparam logic [2:0] RT_BYTE = 3'b000;
  localparam logic [2:0] RT_HALF = 3'b001;
  localparam logic [2:0] RT_WORD = 3'b010;
  localparam logic [2:0] RT_LINE = 3'b100;

  // Only incrementing bursts are ever issued.
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

  // Burst length field: a whole line for refills/write-backs, a single beat otherwise.
  function automatic logic [7:0] axi_len(input logic [2:0] req_type, input int line_words);
    return (req_type == RT_LINE) ? 8'(line_words - 1) : 8'd0;
  endfunction

  // Beat size field: line traffic always moves full 32-bit words.
  function automatic logic [2:0] axi_size(input logic [2:0] req_type);
    return (req_type == RT_LINE) ? 3'd2 : {1'b0, req_type[1:0]};
  endfunction

endpackage

// File: rtl/cache_axi_bridge_wr_channel.sv
// Write path of the bridge: buffers one cache write (line or uncached word),
// issues AW, streams the W beats from the buffer, then waits for B.
module axi_wr_channel
  import cache_axi_bridge_pkg::*;
#(
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wr_req,
  input  logic [2:0]              wr_type,
  input  logic [31:0]             wr_addr,
  input  logic [3:0]              wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                    wr_rdy,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [31:0]             buf_addr,
  output logic                    busy
);

  localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  wr_state_e              state_reg;
  logic [31:0]            addr_reg;
  logic [2:0]             type_reg;
  logic [3:0]             strb_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   awvalid_reg;
  logic                   wvalid_reg;
  logic                   bready_reg;
  logic                   wr_rdy_reg;
  logic [32*LINE_WORDS-1:0] line_flat;
  logic                   capture;

  // The buffer is loaded only when the channel is idle, so it never changes under a pending burst.
  assign capture = wr_req && (state_reg == W_IDLE);

  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_line
    logic [31:0] word_reg;

    // Hold word gi of the line until the next accepted write; cleared on reset.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        word_reg <= '0;
      end else if (capture) begin
        word_reg <= wr_data[32*gi +: 32];
      end
    end

    assign line_flat[32*gi +: 32] = word_reg;
  end

  assign awaddr   = addr_reg;
  assign awlen    = axi_len(type_reg, LINE_WORDS);
  assign awsize   = axi_size(type_reg);
  assign awvalid  = awvalid_reg;
  assign wvalid   = wvalid_reg;
  assign bready   = bready_reg;
  assign wr_rdy   = wr_rdy_reg;
  assign wdata    = line_flat[{cnt_reg, 5'b0} +: 32];
  assign wstrb    = (type_reg == RT_LINE) ? 4'hf : strb_reg;
  assign wlast    = ({{(8-CNT_W){1'b0}}, cnt_reg} == awlen);
  assign buf_addr = addr_reg;
  assign busy     = (state_reg != W_IDLE);

  // Write FSM: AW strictly before W, beat counter stops on the last beat, then wait for B.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= W_IDLE;
      addr_reg    <= '0;
      type_reg    <= RT_BYTE;
      strb_reg    <= '0;
      cnt_reg     <= '0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      wr_rdy_reg  <= 1'b1;
    end else begin
      case (state_reg)
        W_IDLE: begin
          if (wr_req) begin
            addr_reg    <= wr_addr;
            type_reg    <= wr_type;
            strb_reg    <= wr_wstrb;
            awvalid_reg <= 1'b1;
            wr_rdy_reg  <= 1'b0;
            state_reg   <= W_AW;
          end
        end
        W_AW: begin
          if (awready) begin
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b1;
            cnt_reg     <= '0;
            state_reg   <= W_DATA;
          end
        end
        W_DATA: begin
          if (wready) begin
            if (wlast) begin
              wvalid_reg <= 1'b0;
              bready_reg <= 1'b1;
              state_reg  <= W_RESP;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        W_RESP: begin
          if (bvalid) begin
            bready_reg <= 1'b0;
            wr_rdy_reg <= 1'b1;
            state_reg  <= W_IDLE;
          end
        end
        default: state_reg <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache-to-AXI bridge: read FSM (AR then R pass-through) plus the buffered write
// channel, with a same-line check that keeps reads behind a pending write.
module cache_axi_bridge
  import cache_axi_bridge_pkg::*;
#(
  parameter int         LINE_WORDS = DEFAULT_LINE_WORDS,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                     clk,
  input  logic                     resetn,
  // cache read channel
  input  logic                     rd_req,
  input  logic [2:0]               rd_type,
  input  logic [31:0]              rd_addr,
  output logic                     rd_rdy,
  output logic                     ret_valid,
  output logic                     ret_last,
  output logic [31:0]              ret_data,
  // cache write channel
  input  logic                     wr_req,
  input  logic [2:0]               wr_type,
  input  logic [31:0]              wr_addr,
  input  logic [3:0]               wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                     wr_rdy,
  // AXI AR
  output logic [3:0]               arid,
  output logic [31:0]              araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  // AXI R
  input  logic [3:0]               rid,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  // AXI AW
  output logic [3:0]               awid,
  output logic [31:0]              awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic                     awvalid,
  input  logic                     awready,
  // AXI W
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  // AXI B
  input  logic [3:0]               bid,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready
);

  rd_state_e   rd_state_reg;
  logic [31:0] rd_addr_reg;
  logic [2:0]  rd_type_reg;
  logic        arvalid_reg;
  logic        rready_reg;
  logic [31:0] wr_buf_addr;
  logic        wr_busy;
  logic        hazard;
  logic        unused_inputs;

  // Response IDs and status codes carry no information for this single-ID, error-agnostic bridge.
  assign unused_inputs = ^{rid, rresp, bid, bresp};

  // Stall a read whose line matches a write that has not yet been acknowledged.
  assign hazard = wr_busy && (rd_addr[31:4] == wr_buf_addr[31:4]);
  assign rd_rdy = (rd_state_reg == R_IDLE) && !hazard;

  assign arid    = AXI_ID;
  assign araddr  = rd_addr_reg;
  assign arlen   = axi_len(rd_type_reg, LINE_WORDS);
  assign arsize  = axi_size(rd_type_reg);
  assign arburst = AXI_BURST_INCR;
  assign arvalid = arvalid_reg;
  assign rready  = rready_reg;

  // Returned beats pass straight through while the data phase is open.
  assign ret_valid = rready_reg && rvalid;
  assign ret_last  = rready_reg && rlast;
  assign ret_data  = rdata;

  assign awid    = AXI_ID;
  assign awburst = AXI_BURST_INCR;

  // Read FSM: latch the request, present AR until accepted, then forward R until rlast.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state_reg <= R_IDLE;
      rd_addr_reg  <= '0;
      rd_type_reg  <= RT_BYTE;
      arvalid_reg  <= 1'b0;
      rready_reg   <= 1'b0;
    end else begin
      case (rd_state_reg)
        R_IDLE: begin
          if (rd_req && rd_rdy) begin
            rd_addr_reg  <= rd_addr;
            rd_type_reg  <= rd_type;
            arvalid_reg  <= 1'b1;
            rd_state_reg <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            arvalid_reg  <= 1'b0;
            rready_reg   <= 1'b1;
            rd_state_reg <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid && rlast) begin
            rready_reg   <= 1'b0;
            rd_state_reg <= R_IDLE;
          end
        end
        default: rd_state_reg <= R_IDLE;
      endcase
    end
  end

  axi_wr_channel #(
    .LINE_WORDS(LINE_WORDS)
  ) u_wr (
    .clk      (clk),
    .resetn   (resetn),
    .wr_req   (wr_req),
    .wr_type  (wr_type),
    .wr_addr  (wr_addr),
    .wr_wstrb (wr_wstrb),
    .wr_data  (wr_data),
    .wr_rdy   (wr_rdy),
    .awaddr   (awaddr),
    .awlen    (awlen),
    .awsize   (awsize),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .wvalid   (wvalid),
    .wready   (wready),
    .bvalid   (bvalid),
    .bready   (bready),
    .buf_addr (wr_buf_addr),
    .busy     (wr_busy)
  );

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: table-driven read/write transactions
// plus hand-written hazard, simultaneous-accept and mid-burst reset sequences.
module tb_cache_axi_bridge;
  import cache_axi_bridge_pkg::*;

  localparam int LW = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          rd_req = 0, rd_rdy, ret_valid, ret_last;
  logic [2:0]    rd_type = 0;
  logic [31:0]   rd_addr = 0, ret_data;
  logic          wr_req = 0, wr_rdy;
  logic [2:0]    wr_type = 0;
  logic [31:0]   wr_addr = 0;
  logic [3:0]    wr_wstrb = 0;
  logic [32*LW-1:0] wr_data = 0;
  logic [3:0]    arid, awid;
  logic [31:0]   araddr, awaddr, wdata;
  logic [7:0]    arlen, awlen;
  logic [2:0]    arsize, awsize;
  logic [1:0]    arburst, awburst;
  logic          arvalid, awvalid, wvalid, wlast, rready, bready;
  logic [3:0]    wstrb;
  logic          arready = 0, awready = 0, wready = 0;
  logic [3:0]    rid = 0, bid = 0;
  logic [31:0]   rdata = 0;
  logic [1:0]    rresp = 0, bresp = 0;
  logic          rlast = 0, rvalid = 0, bvalid = 0;

  cache_axi_bridge #(.LINE_WORDS(LW), .AXI_ID(4'd0)) dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  rtype;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    int          ar_delay;
  } rd_vec_t;

  typedef struct {
    logic [2:0]    wtype;
    logic [31:0]   addr;
    logic [3:0]    strb;
    logic [127:0]  data;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [3:0]    exp_strb;
    int            aw_delay;
    int            w_delay;
  } wr_vec_t;

  rd_vec_t rv[4];
  wr_vec_t wv[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input rd_vec_t v);
    int nb;
    logic [31:0] beat;
    nb = int'(v.len) + 1;
    $display("read  type=%b addr=%h beats=%0d", v.rtype, v.addr, nb);
    rd_req = 1; rd_type = v.rtype; rd_addr = v.addr;
    #1;
    chk("rd_rdy_idle", rd_rdy, 1);
    step();
    rd_req = 0;
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, v.addr);
    chk("arlen", arlen, v.len);
    chk("arsize", arsize, v.size);
    chk("arburst", arburst, 2'b01);
    chk("arid", arid, 0);
    chk("rd_rdy_busy", rd_rdy, 0);
    for (int k = 0; k < v.ar_delay; k++) begin
      step();
      chk("arvalid_hold", arvalid, 1);
      chk("araddr_hold", araddr, v.addr);
    end
    arready = 1;
    step();
    arready = 0;
    chk("arvalid_done", arvalid, 0);
    chk("rready", rready, 1);
    for (int i = 0; i < nb; i++) begin
      if (i == 1) begin
        rvalid = 0;
        #1;
        chk("ret_valid_gap", ret_valid, 0);
        step();
      end
      beat = 32'hA000_0000 + v.addr + i;
      rvalid = 1; rdata = beat; rlast = (i == nb - 1);
      #1;
      chk("ret_valid", ret_valid, 1);
      chk("ret_data", ret_data, beat);
      chk("ret_last", ret_last, (i == nb - 1) ? 1 : 0);
      step();
    end
    rvalid = 0; rlast = 0;
    #1;
    chk("rready_done", rready, 0);
    chk("rd_rdy_after", rd_rdy, 1);
  endtask

  task automatic do_write(input wr_vec_t v);
    logic [31:0] exp_word;
    $display("write type=%b addr=%h len=%0d", v.wtype, v.addr, v.len);
    chk("wr_rdy_idle", wr_rdy, 1);
    wr_req = 1; wr_type = v.wtype; wr_addr = v.addr; wr_wstrb = v.strb; wr_data = v.data;
    step();
    wr_req = 0;
    wr_data = ~v.data;
    chk("awvalid", awvalid, 1);
    chk("awaddr", awaddr, v.addr);
    chk("awlen", awlen, v.len);
    chk("awsize", awsize, v.size);
    chk("awburst", awburst, 2'b01);
    chk("awid", awid, 0);
    chk("wvalid_before_aw", wvalid, 0);
    chk("wr_rdy_busy", wr_rdy, 0);
    for (int k = 0; k < v.aw_delay; k++) begin
      step();
      chk("awvalid_hold", awvalid, 1);
      chk("awaddr_hold", awaddr, v.addr);
      chk("wvalid_early", wvalid, 0);
    end
    awready = 1;
    step();
    awready = 0;
    chk("awvalid_done", awvalid, 0);
    for (int i = 0; i <= int'(v.len); i++) begin
      exp_word = v.data[32*i +: 32];
      for (int k = 0; k < v.w_delay; k++) begin
        chk("wvalid_hold", wvalid, 1);
        chk("wdata_hold", wdata, exp_word);
        step();
      end
      wready = 1;
      #1;
      chk("wvalid", wvalid, 1);
      chk("wdata", wdata, exp_word);
      chk("wstrb", wstrb, v.exp_strb);
      chk("wlast", wlast, (i == int'(v.len)) ? 1 : 0);
      step();
      wready = 0;
    end
    chk("wvalid_done", wvalid, 0);
    chk("bready", bready, 1);
    chk("wr_rdy_resp", wr_rdy, 0);
    step();
    chk("wr_rdy_wait_b", wr_rdy, 0);
    bvalid = 1;
    step();
    bvalid = 0;
    chk("bready_done", bready, 0);
    chk("wr_rdy_after_b", wr_rdy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rv[0] = '{RT_LINE, 32'h1c00_0040, 8'd3, 3'd2, 0};
    rv[1] = '{RT_BYTE, 32'h1faf_0001, 8'd0, 3'd0, 2};
    rv[2] = '{RT_HALF, 32'h0000_1002, 8'd0, 3'd1, 0};
    rv[3] = '{RT_WORD, 32'h0000_2004, 8'd0, 3'd2, 1};

    wv[0] = '{RT_LINE, 32'h0000_0100, 4'h0,
              {32'h44, 32'h33, 32'h22, 32'h11}, 8'd3, 3'd2, 4'hf, 0, 0};
    wv[1] = '{RT_WORD, 32'h1faf_0008, 4'b0011,
              {32'hffff_ffff, 32'heeee_eeee, 32'hdddd_dddd, 32'hdead_beef}, 8'd0, 3'd2, 4'b0011, 5, 3};
    wv[2] = '{RT_HALF, 32'h0000_0406, 4'b1100,
              {32'h0, 32'h0, 32'h0, 32'h1234_5678}, 8'd0, 3'd1, 4'b1100, 1, 0};
    wv[3] = '{RT_LINE, 32'h0000_0300, 4'h5,
              {32'hc3c3_0003, 32'hc2c2_0002, 32'hc1c1_0001, 32'hc0c0_0000}, 8'd3, 3'd2, 4'hf, 0, 1};

    // Reset state
    #12;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_ret_valid", ret_valid, 0);
    step();
    resetn = 1;
    #1;
    chk("rst_rd_rdy", rd_rdy, 1);
    chk("rst_wr_rdy", wr_rdy, 1);

    for (int i = 0; i < 4; i++) do_read(rv[i]);
    for (int i = 0; i < 3; i++) do_write(wv[i]);

    // Read-after-write hazard on line 0x80; an unrelated line goes through meanwhile.
    $display("hazard write 0x80 / read 0x84 / read 0x200");
    step();
    wr_req = 1; wr_type = RT_WORD; wr_addr = 32'h80; wr_wstrb = 4'hf; wr_data = 128'h0;
    wr_data[31:0] = 32'h0000_0080;
    step();
    wr_req = 0;
    rd_req = 1; rd_type = RT_WORD; rd_addr = 32'h84;
    #1;
    chk("hazard_aw", rd_rdy, 0);
    awready = 1;
    step();
    awready = 0;
    chk("hazard_w", rd_rdy, 0);
    chk("hazard_no_ar", arvalid, 0);
    wready = 1;
    step();
    wready = 0;
    chk("hazard_b", rd_rdy, 0);
    chk("hazard_bready", bready, 1);
    rd_addr = 32'h200;
    #1;
    chk("other_line_rdy", rd_rdy, 1);
    step();
    rd_req = 0;
    chk("other_line_ar", arvalid, 1);
    chk("other_line_araddr", araddr, 32'h200);
    chk("other_line_wr_rdy", wr_rdy, 0);
    bvalid = 1;
    step();
    bvalid = 0;
    chk("hazard_wr_rdy", wr_rdy, 1);
    arready = 1;
    step();
    arready = 0;
    rvalid = 1; rlast = 1; rdata = 32'h5a5a_0200;
    #1;
    chk("other_line_ret", ret_data, 32'h5a5a_0200);
    step();
    rvalid = 0; rlast = 0;
    rd_addr = 32'h84;
    #1;
    chk("hazard_cleared", rd_rdy, 1);

    // Read and write accepted in the same cycle; AR and AW valid together.
    $display("simultaneous read 0x3000 / write 0x4000");
    rd_req = 1; rd_type = RT_WORD; rd_addr = 32'h3000;
    wr_req = 1; wr_type = RT_WORD; wr_addr = 32'h4000; wr_wstrb = 4'hf;
    wr_data = {96'h0, 32'h7777_4000};
    #1;
    chk("sim_rd_rdy", rd_rdy, 1);
    chk("sim_wr_rdy", wr_rdy, 1);
    step();
    rd_req = 0; wr_req = 0;
    chk("sim_arvalid", arvalid, 1);
    chk("sim_awvalid", awvalid, 1);
    arready = 1; awready = 1;
    step();
    arready = 0; awready = 0;
    chk("sim_rready", rready, 1);
    chk("sim_wdata", wdata, 32'h7777_4000);
    rvalid = 1; rlast = 1; rdata = 32'h3333_3000; wready = 1;
    #1;
    chk("sim_ret_last", ret_last, 1);
    chk("sim_wlast", wlast, 1);
    step();
    rvalid = 0; rlast = 0; wready = 0;
    bvalid = 1;
    step();
    bvalid = 0;
    chk("sim_wr_rdy_end", wr_rdy, 1);
    chk("sim_rd_rdy_end", rd_rdy, 1);

    // Reset in the middle of a write-back burst, then a clean write from beat 0.
    $display("reset during write-back 0x300 after beat 2");
    wr_req = 1; wr_type = RT_LINE; wr_addr = 32'h300; wr_wstrb = 4'h0;
    wr_data = {32'hb3, 32'hb2, 32'hb1, 32'hb0};
    step();
    wr_req = 0;
    awready = 1;
    step();
    awready = 0;
    wready = 1;
    step();
    step();
    wready = 0;
    chk("mid_wdata_beat2", wdata, 32'hb2);
    resetn = 0;
    #1;
    chk("mid_rst_awvalid", awvalid, 0);
    chk("mid_rst_wvalid", wvalid, 0);
    chk("mid_rst_bready", bready, 0);
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_rready", rready, 0);
    step();
    resetn = 1;
    #1;
    chk("post_rst_wr_rdy", wr_rdy, 1);
    do_write(wv[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
